pearson_byte_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the shared 8-input, 8-bit byte multiplexer in the Pearson hash front end.
- Eight byte sources each stream a message. The block grants one source at a time, drives the mux select and enable, and presents the selected byte to the hash core over a valid/ready handshake.
- The grant is locked for a whole message, so hash state is never interleaved between messages.
- Sits between the byte sources and the Pearson hash core. It contains the 8:1 mux instance and also exports the mux controls for observation.

---
 rtl/pearson_byte_arbiter.sv | 149 ++++++++++++++
 tb/tb_pearson_byte_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pearson_byte_arbiter.sv
// Round-robin, message-locked arbiter that feeds the Pearson hash core through an 8:1 byte mux.
// Define ARB_TIMEOUT_EN to force-release a grant whose owner stalls for TIMEOUT cycles.

module pearson_byte_mux8 #(
  parameter int NREQ = 8,
  parameter int DW   = 8,
  parameter int SW   = 3
) (
  input  logic [NREQ*DW-1:0] data_in,
  input  logic [SW-1:0]      sel,
  input  logic               en,
  output logic [DW-1:0]      data_out
);

  assign data_out = en ? data_in[sel*DW +: DW] : '0;

endmodule

module pearson_byte_arbiter #(
  parameter int NREQ    = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    last,
  input  logic [NREQ*DW-1:0] data_in,
  output logic [NREQ-1:0]    ack,
  output logic [2:0]         mux_sel,
  output logic               mux_en,
  output logic [DW-1:0]      out_data,
  output logic               out_valid,
  output logic               out_last,
  input  logic               out_ready,
  output logic               busy,
  output logic               timeout
);

  localparam int SW = $clog2(NREQ);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] owner_q, owner_d;
  logic [SW-1:0] pick;
  logic [SW-1:0] cand;
  logic          found;
  logic          owner_req;
  logic          owner_last;
  logic          xfer;
  logic          expire;

  assign owner_req  = req[owner_q];
  assign owner_last = last[owner_q];
  assign busy       = (state_q == BUSY);
  assign mux_en     = busy;
  assign mux_sel    = busy ? owner_q : '0;

  // A byte is never offered while reset is asserted, so an aborted message gets no ack.
  assign out_valid  = busy & owner_req & ~rst;
  assign out_last   = out_valid & owner_last;
  assign xfer       = out_valid & out_ready;
  assign ack        = xfer ? (NREQ'(1) << owner_q) : '0;

  pearson_byte_mux8 #(
    .NREQ (NREQ),
    .DW   (DW),
    .SW   (SW)
  ) u_mux (
    .data_in  (data_in),
    .sel      (mux_sel),
    .en       (mux_en),
    .data_out (out_data)
  );

  // Rotating-priority pick: first requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    pick  = ptr_q;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr_q + SW'(k);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] stall_cnt_q;

  assign expire  = busy & ~owner_req & ~rst & (stall_cnt_q == CW'(TIMEOUT - 1));
  assign timeout = expire;

  always_ff @(posedge clk) begin
    if (rst || !busy || owner_req || expire) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + CW'(1);
    end
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0 && (TIMEOUT > 0);
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (req != '0) begin
          owner_d = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Priority moves past the owner whether it finished or was forced out.
        if ((xfer && owner_last) || expire) begin
          ptr_d   = owner_q + SW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: tb/tb_pearson_byte_arbiter.sv
// Self-checking bench for pearson_byte_arbiter: directed scenarios then randomized message traffic
// compared against a message-level reference model.

module tb_pearson_byte_arbiter;

  localparam int NREQ    = 8;
  localparam int DW      = 8;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  req;
  logic [7:0]  last;
  logic [63:0] data_in;
  logic [7:0]  ack;
  logic [2:0]  mux_sel;
  logic        mux_en;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic        busy;
  logic        timeout;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] src_byte [8];

  // Reference model: who holds the grant, where priority starts, how long the owner has stalled.
  bit         m_busy;
  int         m_ptr;
  int         m_owner;
  int         m_lowrun;
  logic [7:0] m_ack;

  pearson_byte_arbiter #(
    .NREQ    (NREQ),
    .DW      (DW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .last      (last),
    .data_in   (data_in),
    .ack       (ack),
    .mux_sel   (mux_sel),
    .mux_en    (mux_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  function automatic int first_from(int p, logic [7:0] r);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return 0;
  endfunction

  task automatic checkValue(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [7:0] rq, input logic [7:0] lst,
                               input logic rdy);
    rst       = r;
    req       = rq;
    last      = lst;
    out_ready = rdy;
    for (int i = 0; i < 8; i++) data_in[8*i +: 8] = src_byte[i];
  endtask

  task automatic checkOutput(string tag);
    logic       e_valid;
    logic       e_to;
    logic [7:0] e_data;
    #2;
    e_valid = m_busy && !rst && req[m_owner];
    e_data  = m_busy ? src_byte[m_owner] : 8'h00;
    m_ack   = (e_valid && out_ready) ? (8'h01 << m_owner) : 8'h00;
`ifdef ARB_TIMEOUT_EN
    e_to = m_busy && !rst && !req[m_owner] && (m_lowrun + 1 == TIMEOUT);
`else
    e_to = 1'b0;
`endif
    checkValue({tag, ".busy"}, busy, m_busy);
    checkValue({tag, ".mux_en"}, mux_en, m_busy);
    if (m_busy) checkValue({tag, ".mux_sel"}, mux_sel, m_owner[2:0]);
    checkValue({tag, ".out_valid"}, out_valid, e_valid);
    checkValue({tag, ".out_last"}, out_last, e_valid && last[m_owner]);
    checkValue({tag, ".out_data"}, out_data, e_data);
    checkValue({tag, ".ack"}, ack, m_ack);
    checkValue({tag, ".timeout"}, timeout, e_to);
  endtask

  task automatic modelUpdate();
    if (rst) begin
      m_busy   = 0;
      m_ptr    = 0;
      m_owner  = 0;
      m_lowrun = 0;
    end else if (!m_busy) begin
      m_lowrun = 0;
      if (req != 8'h00) begin
        m_owner = first_from(m_ptr, req);
        m_busy  = 1;
      end
    end else if (req[m_owner]) begin
      m_lowrun = 0;
      if (out_ready && last[m_owner]) begin
        m_ptr  = (m_owner + 1) % 8;
        m_busy = 0;
      end
    end else begin
      m_lowrun++;
`ifdef ARB_TIMEOUT_EN
      if (m_lowrun == TIMEOUT) begin
        m_ptr    = (m_owner + 1) % 8;
        m_busy   = 0;
        m_lowrun = 0;
      end
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
  endtask

  initial begin
    int         seq [4];
    bit         act [8];
    int         len [8];
    logic [7:0] rq;
    logic [7:0] lst;
    logic [7:0] bytes [3];

    seq = '{0, 7, 0, 7};
    bytes = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 8; i++) src_byte[i] = 8'h00;

    // Reset, then idle with no requests
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b1);
    tick();
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
      checkOutput("reset");
      checkValue("reset.mux_sel", mux_sel, 3'd0);
      checkValue("reset.busy_k", busy, 1'b0);
      tick();
    end

    // Single source 3 sends three bytes
    applyStimulus(1'b0, 8'h08, 8'h00, 1'b1);
    src_byte[3] = bytes[0];
    applyStimulus(1'b0, 8'h08, 8'h00, 1'b1);
    checkOutput("single.req");
    checkValue("single.req_valid", out_valid, 1'b0);
    tick();
    for (int b = 0; b < 3; b++) begin
      src_byte[3] = bytes[b];
      applyStimulus(1'b0, 8'h08, (b == 2) ? 8'h08 : 8'h00, 1'b1);
      checkOutput("single.byte");
      checkValue("single.data_k", out_data, bytes[b]);
      checkValue("single.ack_k", ack, 8'h08);
      checkValue("single.last_k", out_last, b == 2);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("single.bubble");
    checkValue("single.bubble_busy", busy, 1'b0);
    tick();

    // Contention between sources 0 and 7 from ptr = 0
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b1);
    tick();
    src_byte[0] = 8'hA0;
    src_byte[7] = 8'hB7;
    for (int g = 0; g < 4; g++) begin
      applyStimulus(1'b0, 8'h81, 8'h81, 1'b1);
      checkOutput("cont.idle");
      tick();
      checkOutput("cont.grant");
      checkValue("cont.sel_k", mux_sel, seq[g][2:0]);
      checkValue("cont.ack_k", ack, 8'h01 << seq[g]);
      tick();
    end

    // Backpressure on owner 2
    src_byte[2] = 8'hA5;
    applyStimulus(1'b0, 8'h04, 8'h04, 1'b0);
    checkOutput("bp.idle");
    tick();
    for (int c = 0; c < 4; c++) begin
      checkOutput("bp.stall");
      checkValue("bp.data_k", out_data, 8'hA5);
      checkValue("bp.ack_k", ack, 8'h00);
      tick();
    end
    applyStimulus(1'b0, 8'h04, 8'h04, 1'b1);
    checkOutput("bp.accept");
    checkValue("bp.accept_k", ack, 8'h04);
    tick();

    // Owner 5 pauses mid-message while source 1 waits
    src_byte[5] = 8'h51;
    applyStimulus(1'b0, 8'h20, 8'h00, 1'b1);
    checkOutput("gap.idle");
    tick();
    checkOutput("gap.first");
    tick();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 8'h02, 8'h00, 1'b1);
      checkOutput("gap.hold");
      checkValue("gap.sel_k", mux_sel, 3'd5);
      checkValue("gap.valid_k", out_valid, 1'b0);
      tick();
    end
    src_byte[5] = 8'h52;
    applyStimulus(1'b0, 8'h22, 8'h22, 1'b1);
    checkOutput("gap.lastbyte");
    checkValue("gap.ack_k", ack, 8'h20);
    tick();
    applyStimulus(1'b0, 8'h02, 8'h02, 1'b1);
    checkOutput("gap.bubble");
    tick();
    checkOutput("gap.next");
    checkValue("gap.next_sel", mux_sel, 3'd1);
    tick();

    // Owner 4 stalls for a long time
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b1);
    tick();
    src_byte[4] = 8'h44;
    applyStimulus(1'b0, 8'h10, 8'h00, 1'b1);
    checkOutput("stall.idle");
    tick();
    checkOutput("stall.first");
    tick();
    applyStimulus(1'b0, 8'h09, 8'h09, 1'b1);
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < 16; c++) begin
      checkOutput("stall.wait");
      checkValue("stall.pulse", timeout, c == 15);
      checkValue("stall.ack0", ack, 8'h00);
      tick();
    end
    checkOutput("stall.released");
    checkValue("stall.busy_k", busy, 1'b0);
    tick();
    checkOutput("stall.regrant");
    checkValue("stall.regrant_sel", mux_sel, 3'd0);
    tick();
`else
    for (int c = 0; c < 20; c++) begin
      checkOutput("stall.hold");
      checkValue("stall.busy_k", busy, 1'b1);
      checkValue("stall.sel_k", mux_sel, 3'd4);
      tick();
    end
`endif

    // Randomized message traffic with stalls, backpressure and occasional reset
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b1);
    tick();
    for (int i = 0; i < 8; i++) begin
      act[i] = 0;
      len[i] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 8; i++) begin
        if (!act[i] && $urandom_range(3) == 0) begin
          act[i]      = 1;
          len[i]      = $urandom_range(4, 1);
          src_byte[i] = 8'($urandom);
        end
        rq[i]  = act[i] && ($urandom_range(4) != 0);
        lst[i] = (len[i] == 1);
      end
      applyStimulus($urandom_range(199) == 0, rq, lst, $urandom_range(3) != 0);
      checkOutput("rand");
      tick();
      for (int i = 0; i < 8; i++) begin
        if (m_ack[i]) begin
          len[i]--;
          if (len[i] == 0) act[i] = 0;
          else src_byte[i] = 8'($urandom);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
